// File: rtl/fp_accum_seq.sv
// Streaming accumulator of operand magnitudes using an external combinational fp_adder.
// Handles zero operands, first-operand direct load, sticky overflow lock and result handshake.
module fp_accum_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready,
  output logic             neg_seen,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for the first operand of a stream
  // ACCUM | stream in progress, operands being summed
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [31:0]      POS_INF = 32'h7F80_0000;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [31:0]      acc, acc_nxt;
  logic             acc_nz, acc_nz_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             neg_nxt, ovf_nxt;

  logic        accept;
  logic [31:0] opm;
  logic        op_zero;
  logic        do_load;
  logic        do_add;
  logic        add_ovf;

  assign accept  = in_valid & in_ready;
  assign opm     = {1'b0, in_data[30:0]};
  assign op_zero = (opm[30:23] == 8'h00);
  assign do_load = accept & ~op_zero & ~acc_nz;
  // once overflowed, acc is pinned at +inf and the adder is left idle
  assign do_add  = accept & ~op_zero & acc_nz & ~ovf;
  assign add_ovf = do_add & ((add_sum[30:23] == 8'hFF) | (add_sum[30:23] < acc[30:23]));

  assign add_a = acc;
  assign add_b = do_add ? opm : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= 32'h0;
      acc_nz   <= 1'b0;
      count    <= '0;
      neg_seen <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      acc_nz   <= acc_nz_nxt;
      count    <= count_nxt;
      neg_seen <= neg_nxt;
      ovf      <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    acc_nz_nxt = acc_nz;
    count_nxt  = count;
    neg_nxt    = neg_seen;
    ovf_nxt    = ovf;
    in_ready   = (state != DONE);
    out_valid  = (state == DONE);
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_nxt = in_last ? DONE : ACCUM;
          count_nxt = (count == CNT_MAX) ? count : count + 1'b1;
          neg_nxt   = neg_seen | in_data[31];
          if (do_load) begin
            acc_nxt    = opm;
            acc_nz_nxt = 1'b1;
          end
          if (do_add) begin
            acc_nxt = add_ovf ? POS_INF : add_sum;
            ovf_nxt = ovf | add_ovf;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt  = IDLE;
          acc_nxt    = 32'h0;
          acc_nz_nxt = 1'b0;
          count_nxt  = '0;
          neg_nxt    = 1'b0;
          ovf_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_data  = out_valid ? acc : 32'h0;
  assign out_count = out_valid ? count : '0;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Randomized scoreboard bench for fp_accum_seq with a truncating fp_adder model
// and a stream-level reference model of the accumulation rules.
module tb_fp_accum_seq;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, in_ready;
  logic [31:0] in_data, add_a, add_b, add_sum, out_data;
  logic out_valid, out_ready, neg_seen, ovf;
  logic [CNT_W-1:0] out_count;

  always #5 clk = ~clk;

  fp_accum_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .out_ready(out_ready), .neg_seen(neg_seen), .ovf(ovf)
  );

  // positive-only adder, truncating, saturating to +inf
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ea, eb, t;
    logic [24:0] ma, mb, s;
    int e, d;
    if (b[30:23] == 8'h00) return a;
    if (a[30:23] == 8'h00) return b;
    ea = a[30:23]; eb = b[30:23];
    ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
    if (eb > ea) begin
      t = ea; ea = eb; eb = t;
      s = ma; ma = mb; mb = s;
    end
    d = int'(ea) - int'(eb);
    mb = (d > 24) ? 25'h0 : (mb >> d);
    s = ma + mb;
    e = int'(ea);
    if (s[24]) begin s = s >> 1; e = e + 1; end
    if (e >= 255) return 32'h7F80_0000;
    return {1'b0, 8'(e), s[22:0]};
  endfunction

  assign add_sum = fadd(add_a, add_b);

  typedef struct {
    logic [31:0] d;
    int          c;
    bit          neg;
    bit          ov;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  bit ready_auto = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ops[$]);
    exp_t r;
    logic [31:0] sum, m, s;
    bit nz, lock;
    sum = 32'h0; nz = 0; lock = 0;
    r.neg = 0; r.ov = 0;
    foreach (ops[i]) begin
      m = {1'b0, ops[i][30:0]};
      if (ops[i][31]) r.neg = 1;
      if (m[30:23] == 8'h00 || lock) continue;
      if (!nz) begin
        sum = m; nz = 1;
      end else begin
        s = fadd(sum, m);
        if (s[30:23] == 8'hFF || s[30:23] < sum[30:23]) begin
          sum = 32'h7F80_0000; lock = 1; r.ov = 1;
        end else sum = s;
      end
    end
    r.d = sum;
    r.c = (ops.size() > CNT_MAX) ? CNT_MAX : ops.size();
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic l, input bit noadd);
    int guard = 0;
    while (!in_ready && guard < 500) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 500) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    in_valid = 1'b1; in_data = d; in_last = l;
    #1;
    if (noadd) chk("no_add_b", add_b, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (l) begin
      chk("latency_out_valid", {31'h0, out_valid}, 32'h1);
      chk("done_in_ready", {31'h0, in_ready}, 32'h0);
    end
  endtask

  task automatic stream(input logic [31:0] ops[$], input bit use_e, input exp_t e, input bit noadd);
    exp_t r;
    r = use_e ? e : model(ops);
    exp_q.push_back(r);
    foreach (ops[i]) begin
      send(ops[i], (i == ops.size() - 1), noadd);
      if (i != ops.size() - 1 && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic logic [31:0] rand_op();
    int r;
    logic [7:0] ex;
    r = $urandom_range(0, 19);
    if (r < 3)       ex = 8'h00;
    else if (r == 3) ex = 8'(($urandom_range(0, 1) != 0) ? 8'hFE : 8'hFD);
    else             ex = 8'($urandom_range(110, 135));
    return {1'b0 ^ ($urandom_range(0, 3) == 0), ex, 23'($urandom())};
  endfunction

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_result actual=%h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_count", 32'(out_count), 32'(e.c));
            chk("neg_seen", {31'h0, neg_seen}, {31'h0, e.neg});
            chk("ovf", {31'h0, ovf}, {31'h0, e.ov});
          end
        end
      end else begin
        chk("idle_out_data", out_data, 32'h0);
        chk("idle_out_count", 32'(out_count), 32'h0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_auto) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ops[$];
    exp_t e;
    logic [31:0] h_data;
    logic [CNT_W-1:0] h_cnt;
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_count", 32'(out_count), 32'h0);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);
    chk("rst_neg_ovf", {30'h0, neg_seen, ovf}, 32'h0);

    e = '{32'h4080_0000, 3, 1'b0, 1'b0};
    ops = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000}; stream(ops, 1, e, 0);
    e = '{32'h4049_0FDB, 1, 1'b0, 1'b0};
    ops = '{32'h4049_0FDB}; stream(ops, 1, e, 1);
    e = '{32'h4040_0000, 2, 1'b0, 1'b0};
    ops = '{32'h0000_0000, 32'h4040_0000}; stream(ops, 1, e, 0);
    e = '{32'h4000_0000, 2, 1'b1, 1'b0};
    ops = '{32'hBF80_0000, 32'h3F80_0000}; stream(ops, 1, e, 0);
    e = '{32'h7F80_0000, 3, 1'b0, 1'b1};
    ops = '{32'h7F00_0000, 32'h7F00_0000, 32'h3F80_0000}; stream(ops, 1, e, 0);
    e = '{32'h0000_0000, 3, 1'b1, 1'b0};
    ops = '{32'h0000_0000, 32'h8000_1234, 32'h0012_3456}; stream(ops, 1, e, 0);

    // held result under backpressure
    guard = 0;
    while (out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    ready_auto = 1'b0; out_ready = 1'b0;
    e = '{32'h4040_0000, 2, 1'b0, 1'b0};
    ops = '{32'h3F80_0000, 32'h4000_0000}; stream(ops, 1, e, 0);
    h_data = out_data; h_cnt = out_count;
    chk("held_data_first", h_data, 32'h4040_0000);
    repeat (5) begin
      @(posedge clk); #1;
      chk("held_valid", {31'h0, out_valid}, 32'h1);
      chk("held_data", out_data, h_data);
      chk("held_count", 32'(out_count), 32'(h_cnt));
      chk("held_in_ready", {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", {31'h0, out_valid}, 32'h0);
    chk("release_in_ready", {31'h0, in_ready}, 32'h1);
    ready_auto = 1'b1;

    // reset mid-stream discards partial sum
    send(32'h4000_0000, 1'b0, 0);
    send(32'h4100_0000, 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    e = '{32'h3F80_0000, 1, 1'b0, 1'b0};
    ops = '{32'h3F80_0000}; stream(ops, 1, e, 0);

    // count saturation with continued accumulation
    ops = {};
    for (int i = 0; i < 300; i++) ops.push_back({1'b0, 8'd120, 23'($urandom())});
    stream(ops, 0, e, 0);

    for (int s = 0; s < 40; s++) begin
      ops = {};
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) ops.push_back(rand_op());
      stream(ops, 0, e, 0);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin @(posedge clk); guard++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
